nw_cell_feeder: RTL

//  Upstream sequencer for the Max stage of the Needleman-Wunsch score matrix.

---
 rtl/nw_cell_feeder_if.sv | 27 ++
 rtl/nw_cell_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nw_cell_feeder_if.sv
// Candidate/result handshake between the Needleman-Wunsch cell feeder and the
// Max stage, plus the traceback symbol write port.
interface nw_cell_feeder_if #(
    parameter int SCORE_W = 9,
    parameter int ADDR_W  = 6
);
    logic               value;
    logic [SCORE_W-1:0] diag;
    logic [SCORE_W-1:0] up;
    logic [SCORE_W-1:0] lx;
    logic [SCORE_W-1:0] max;
    logic [2:0]         symbol;
    logic               calculated;
    logic               sym_we;
    logic [ADDR_W-1:0]  sym_addr;
    logic [2:0]         sym_data;

    modport master (
        output value, diag, up, lx, sym_we, sym_addr, sym_data,
        input  max, symbol, calculated
    );

    modport slave (
        input  value, diag, up, lx, sym_we, sym_addr, sym_data,
        output max, symbol, calculated
    );
endinterface

// File: rtl/nw_cell_feeder.sv
// Needleman-Wunsch cell feeder: walks the N x N score matrix row-major, builds
// the diag/up/left candidates for each cell, hands them to Max, writes Max's
// result back into a one-row score buffer and streams traceback symbols out.
// Optional feature macro: NW_CLAMP_EN -- candidates (and border values)
// saturate to the signed SCORE_W range instead of wrapping.
module nw_cell_feeder #(
    parameter int N        = 8,
    parameter int SCORE_W  = 9,
    parameter int ADDR_W   = 6,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int GAP      = -2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*N-1:0]     seq_a,
    input  logic [2*N-1:0]     seq_b,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] final_score,
    nw_cell_feeder_if.master   bus
);
    localparam int IDX_W = $clog2(N + 1);

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic signed [SCORE_W:0]   wide_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int SAT_HI = (2 ** (SCORE_W - 1)) - 1;
    localparam int SAT_LO = -(2 ** (SCORE_W - 1));

    // Reduce a signed sum to SCORE_W bits: saturate or two's-complement wrap.
    function automatic score_t fit(input int v);
`ifdef NW_CLAMP_EN
        if (v > SAT_HI) begin
            return score_t'(SAT_HI);
        end else if (v < SAT_LO) begin
            return score_t'(SAT_LO);
        end else begin
            return score_t'(v);
        end
`else
        return score_t'(v);
`endif
    endfunction

    state_t             state_r, state_nxt_s;
    logic [1:0]         base_a_r [0:N];
    logic [1:0]         base_b_r [0:N];
    score_t             row_r    [0:N];
    score_t             dreg_r, left_r;
    logic [IDX_W-1:0]   i_r, j_r;
    logic               busy_r, done_r, value_r, sym_we_r;
    score_t             diag_r, up_r, lx_r, final_r;
    logic [ADDR_W-1:0]  sym_addr_r;
    logic [2:0]         sym_data_r;
    wide_t              diag_sum_s, up_sum_s, lx_sum_s;
    logic               last_s;

    assign last_s       = (i_r == IDX_W'(N)) && (j_r == IDX_W'(N));
    assign busy         = busy_r;
    assign done         = done_r;
    assign final_score  = final_r;
    assign bus.value    = value_r;
    assign bus.diag     = diag_r;
    assign bus.up       = up_r;
    assign bus.lx       = lx_r;
    assign bus.sym_we   = sym_we_r;
    assign bus.sym_addr = sym_addr_r;
    assign bus.sym_data = sym_data_r;

    // Candidate sums for the current cell, one bit wider than a score.
    always_comb begin
        diag_sum_s = wide_t'(dreg_r);
        if (base_a_r[i_r] == base_b_r[j_r]) begin
            diag_sum_s = wide_t'(dreg_r) + wide_t'(MATCH);
        end else begin
            diag_sum_s = wide_t'(dreg_r) + wide_t'(MISMATCH);
        end
        up_sum_s = wide_t'(row_r[j_r]) + wide_t'(GAP);
        lx_sum_s = wide_t'(left_r) + wide_t'(GAP);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INIT:  state_nxt_s = ST_ISSUE;
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.calculated) begin
                    state_nxt_s = ST_UPDATE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_UPDATE: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: sequence latch, row buffer, cell indices and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= N; k++) begin
                base_a_r[k] <= 2'b00;
                base_b_r[k] <= 2'b00;
                row_r[k]    <= score_t'(0);
            end
            dreg_r     <= score_t'(0);
            left_r     <= score_t'(0);
            i_r        <= IDX_W'(1);
            j_r        <= IDX_W'(1);
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            value_r    <= 1'b0;
            sym_we_r   <= 1'b0;
            diag_r     <= score_t'(0);
            up_r       <= score_t'(0);
            lx_r       <= score_t'(0);
            final_r    <= score_t'(0);
            sym_addr_r <= {ADDR_W{1'b0}};
            sym_data_r <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 1; k <= N; k++) begin
                            base_a_r[k] <= seq_a[2*k-2 +: 2];
                            base_b_r[k] <= seq_b[2*k-2 +: 2];
                        end
                        busy_r <= 1'b1;
                    end
                end
                ST_INIT: begin
                    for (int k = 0; k <= N; k++) begin
                        row_r[k] <= fit(k * GAP);
                    end
                    i_r    <= IDX_W'(1);
                    j_r    <= IDX_W'(1);
                    left_r <= fit(GAP);
                    dreg_r <= score_t'(0);
                end
                ST_ISSUE: begin
                    diag_r  <= fit(int'(diag_sum_s));
                    up_r    <= fit(int'(up_sum_s));
                    lx_r    <= fit(int'(lx_sum_s));
                    value_r <= 1'b1;
                end
                ST_WAIT: begin
                    // Candidates hold until Max answers; the answer is folded in here.
                    if (bus.calculated) begin
                        value_r    <= 1'b0;
                        sym_we_r   <= 1'b1;
                        sym_addr_r <= ADDR_W'((int'(i_r) - 1) * N + int'(j_r) - 1);
                        sym_data_r <= bus.symbol;
                        dreg_r     <= row_r[j_r];
                        row_r[j_r] <= bus.max;
                        left_r     <= bus.max;
                        if (last_s) begin
                            final_r <= bus.max;
                        end
                    end
                end
                ST_UPDATE: begin
                    sym_we_r <= 1'b0;
                    if (j_r < IDX_W'(N)) begin
                        j_r <= j_r + IDX_W'(1);
                    end else if (i_r < IDX_W'(N)) begin
                        // New row: diagonal and left neighbours come from column 0.
                        i_r    <= i_r + IDX_W'(1);
                        j_r    <= IDX_W'(1);
                        dreg_r <= fit(int'(i_r) * GAP);
                        left_r <= fit((int'(i_r) + 1) * GAP);
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    value_r  <= 1'b0;
                    sym_we_r <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end
endmodule
